program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Writer side of the 16-bit instruction store. Takes a framed byte stream over valid/ready (e.g. UART RX),
//  assembles big-endian 16-bit instruction words and writes them into the instruction RAM's write port.
//  Holds the CPU while a load is in progress.
//  Frame: SYNC_BYTE, N (word count), 2N data bytes (hi byte first), checksum (8-bit sum of the 2N data bytes, mod 256).
// PARAMETERS
//  ADDR_W       4       instruction memory address width; max words = 2**ADDR_W
//  SYNC_BYTE    8'hA5   frame start marker
//  TIMEOUT_CYC  50000   max idle cycles between bytes inside a frame before abort (>=2)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       synchronous, active-low reset
//  rx_data    in   8       incoming byte
//  rx_valid   in   1       rx_data valid this cycle
//  rx_ready   out  1       loader can accept a byte; byte taken when rx_valid & rx_ready
//  mem_we     out  1       instruction RAM write enable (1-cycle pulse per word)
//  mem_addr   out  ADDR_W  write word address
//  mem_wdata  out  16      write word {hi,lo}
//  cpu_hold   out  1       1 = CPU held (load active or failed)
//  load_done  out  1       1-cycle pulse on a successful load
//  load_err   out  1       sticky error flag; cleared when the next SYNC_BYTE is accepted
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous and active-low on rst_n. All outputs are registered.
//  - Reset values: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, load_done=0, load_err=0, timeout counter=0.
//  - rx_ready=0 during reset and 1 in every other cycle, so one byte per cycle is accepted.
//  - IDLE: an accepted byte == SYNC_BYTE -> COUNT, cpu_hold<=1, load_err<=0. Any other byte is dropped silently.
//  - COUNT: accepted byte N. N==0 or N>2**ADDR_W -> ERROR. Otherwise latch N, idx<=0, sum<=0, go to DATA_HI.
//  - DATA_HI: latch hi byte, sum<=sum+byte, go to DATA_LO.
//  - DATA_LO: sum<=sum+byte. In the cycle after acceptance: mem_we=1, mem_addr=idx, mem_wdata={hi,byte}.
//    If idx==N-1 go to CHECK, else idx<=idx+1 and go to DATA_HI.
//  - mem_we is never asserted outside this pulse. mem_addr and mem_wdata hold their last values otherwise.
//  - CHECK: accepted byte == sum[7:0] -> DONE, else ERROR.
//  - DONE (1 cycle): load_done=1, cpu_hold<=0, then IDLE.
//  - ERROR (1 cycle): load_err<=1, cpu_hold stays 1, then IDLE. A new SYNC_BYTE starts a retry.
//    The CPU is released only by a good load or by reset.
//  - Timeout: in COUNT, DATA_HI, DATA_LO and CHECK, a counter increments on each cycle with no accepted byte
//    and clears on each accepted byte. When it reaches TIMEOUT_CYC-1 the FSM goes to ERROR next cycle.
//    The counter is not active in IDLE.
//  - A SYNC_BYTE value received inside a frame is treated as data or count. There is no resync mid-frame.
//  - No rollback: words already written before an ERROR stay in RAM. cpu_hold=1 prevents execution of that partial image.
//  - Reset mid-frame: FSM returns to IDLE, all outputs take reset values (cpu_hold=0), and partial RAM contents remain.
//  - Widths: idx is ADDR_W bits. N is held in ADDR_W+1 bits so N=2**ADDR_W is representable. sum is 8 bits, wrapping.
// TESTING
//  1 Reset: rst_n=0 for 2 clk -> all outputs 0, rx_ready=0; after release rx_ready=1, cpu_hold=0.
//  2 Good frame A5 02 12 34 AB CD BE, back-to-back -> writes (0,1234) then (1,ABCD); load_done 1-cycle pulse;
//    cpu_hold 1 from A5 until DONE; load_err=0.
//  3 Same frame with checksum BF, plus random rx_valid gaps -> both words written; no load_done; load_err=1;
//    cpu_hold stays 1. Then a good frame clears load_err and drops cpu_hold.
//  4 Count edge cases: A5 00 and A5 11 (ADDR_W=4) -> ERROR, no mem_we. A5 10 with 32 data bytes and correct sum
//    -> 16 writes, addresses 0..F, load_done.
//  5 Timeout, TIMEOUT_CYC=16: A5 01 12 then rx_valid=0 -> ERROR exactly 16 idle cycles after the 12 byte;
//    no write; load_err=1.
//  6 Noise then reset: 00 FF 5A in IDLE -> ignored, cpu_hold=0. A5 02 12 34 then rst_n=0 -> IDLE, cpu_hold=0,
//    word 0 = 1234 remains written.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
//   Writer side of the 16-bit instruction store. Receives a framed byte stream over
//   valid/ready, assembles big-endian 16-bit words and writes them to the instruction RAM,
//   holding the CPU while a load is in progress or after a failed one.
//   Frame: SYNC_BYTE, N, 2N data bytes (hi first), checksum = 8-bit sum of the data bytes.
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   rx_data    incoming byte
//   rx_valid   rx_data valid this cycle
//   rx_ready   byte accepted when rx_valid & rx_ready (0 only during reset)
//   mem_we     RAM write enable, one-cycle pulse per assembled word
//   mem_addr   RAM word address
//   mem_wdata  RAM write word {hi,lo}
//   cpu_hold   1 while a load is active or after a failed load
//   load_done  one-cycle pulse on a successful load
//   load_err   sticky error, cleared when the next SYNC_BYTE is accepted
module program_loader #(
   parameter int unsigned ADDR_W      = 4,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam int unsigned NW     = ADDR_W + 1;
   localparam int unsigned MAX_N  = 2 ** ADDR_W;
   localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      StIdle,
      StCount,
      StDataHi,
      StDataLo,
      StCheck,
      StDone,
      StError
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic [NW-1:0]     n_words;   // one extra bit so N = 2**ADDR_W fits
   logic [7:0]        sum;
   logic [7:0]        hi_byte;
   logic [TO_W-1:0]   to_cnt;

   logic accept;
   logic in_frame;
   logic timed_out;

   assign accept    = rx_valid & rx_ready;
   assign in_frame  = (state == StCount) || (state == StDataHi) ||
                      (state == StDataLo) || (state == StCheck);
   assign timed_out = (to_cnt == TO_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= StIdle;
         idx       <= '0;
         n_words   <= '0;
         sum       <= '0;
         hi_byte   <= '0;
         to_cnt    <= '0;
         rx_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         rx_ready  <= 1'b1;
         mem_we    <= 1'b0;
         load_done <= 1'b0;

         // Inter-byte idle counter, only meaningful inside a frame
         if (in_frame && !accept) begin
            to_cnt <= to_cnt + TO_W'(1);
         end else begin
            to_cnt <= '0;
         end

         case (state)
            StIdle: begin
               if (accept && (rx_data == SYNC_BYTE)) begin
                  state    <= StCount;
                  cpu_hold <= 1'b1;
                  load_err <= 1'b0;
               end
            end
            StCount: begin
               if (accept) begin
                  if ((rx_data == 8'd0) || (32'(rx_data) > MAX_N)) begin
                     state    <= StError;
                     load_err <= 1'b1;
                  end else begin
                     n_words <= NW'(rx_data);
                     idx     <= '0;
                     sum     <= '0;
                     state   <= StDataHi;
                  end
               end
            end
            StDataHi: begin
               if (accept) begin
                  hi_byte <= rx_data;
                  sum     <= sum + rx_data;
                  state   <= StDataLo;
               end
            end
            StDataLo: begin
               if (accept) begin
                  sum       <= sum + rx_data;
                  mem_we    <= 1'b1;
                  mem_addr  <= idx;
                  mem_wdata <= {hi_byte, rx_data};
                  if ({1'b0, idx} == (n_words - NW'(1))) begin
                     state <= StCheck;
                  end else begin
                     idx   <= idx + ADDR_W'(1);
                     state <= StDataHi;
                  end
               end
            end
            StCheck: begin
               if (accept) begin
                  if (rx_data == sum) begin
                     state     <= StDone;
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end else begin
                     state    <= StError;
                     load_err <= 1'b1;
                  end
               end
            end
            StDone: begin
               state <= StIdle;
            end
            StError: begin
               // cpu_hold stays set: a partial image must not run
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase

         // Abort on a stalled sender; overrides the in-frame transitions above
         if (in_frame && !accept && timed_out) begin
            state    <= StError;
            load_err <= 1'b1;
         end
      end
   end

endmodule
